fib_req_scheduler: RTL and testbench

FIB_REQ_SCHEDULER -- requirements
Module: fib_req_scheduler

---
 rtl/fib_req_scheduler.sv | 107 ++++++++++
 tb/tb_fib_req_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fib_req_scheduler.sv
// fib_req_scheduler: round-robin arbiter feeding an iterative Fibonacci engine with a
// saturating 32-bit result and a valid/ready response port.
module fib_req_scheduler #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [6*NREQ-1:0]    req_n,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_ovf,
  output logic                 busy,
  output logic [5:0]           cnt
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, gnt;
  logic [5:0] n_q, n_d, cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic ovf_q, ovf_d, found;
  int unsigned idx;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && req_valid[IW'(idx)]) begin
        found = 1'b1;
        gnt = IW'(idx);
      end
    end
  end
  assign req_ready = (state_q == IDLE && found && !rst) ? (NREQ'(1) << gnt) : '0;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    n_d = n_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = CALC;
        ptr_d = (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        id_d = gnt;
        n_d = req_n[6*int'(gnt) +: 6];
        cnt_d = '0;
        a_d = '0;
        b_d = 32'd1;
      end
      CALC: if (n_q >= 6'd48) begin
        // F(48) and beyond do not fit in 32 bits: saturate without iterating
        state_d = RESP;
        data_d = '1;
        ovf_d = 1'b1;
      end else if (cnt_q == n_q) begin
        state_d = RESP;
        data_d = a_q;
        ovf_d = 1'b0;
      end else begin
        a_d = b_q;
        b_d = a_q + b_q;
        cnt_d = cnt_q + 6'd1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      n_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= 32'd1;
      data_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
      ovf_q <= ovf_d;
    end
  end
  assign rsp_valid = (state_q == RESP);
  assign busy = (state_q != IDLE);
  assign rsp_id = id_q;
  assign rsp_data = data_q;
  assign rsp_ovf = ovf_q;
  assign cnt = cnt_q;
endmodule

// File: tb/tb_fib_req_scheduler.sv
// tb_fib_req_scheduler: directed vectors with hand-computed Fibonacci results, latencies and grant order.
module tb_fib_req_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid;
  logic [23:0] req_n;
  logic [3:0] req_ready;
  logic rsp_valid, rsp_ready, rsp_ovf, busy;
  logic [1:0] rsp_id;
  logic [31:0] rsp_data;
  logic [5:0] cnt;
  int n_cmp = 0;
  int n_bad = 0;

  fib_req_scheduler #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int id, input int n);
    req_valid[id] = 1'b1;
    req_n[6*id +: 6] = 6'(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    tick();
    tick();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_ovf", rsp_ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    req_valid = '0;
    rst = 1'b0;
  endtask

  // Grant check in the current IDLE cycle, then wait for the response and check it.
  task automatic serve(input int id, input logic [31:0] d, input logic o, input int lat, input bit drop);
    int cyc;
    #1;
    chk("gnt", req_ready, 64'(4'b0001 << id));
    tick();
    if (drop) req_valid[id] = 1'b0;
    cyc = 1;
    chk("busy_calc", busy, 1);
    while (!rsp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("lat", cyc, lat);
    chk("data", rsp_data, d);
    chk("id", rsp_id, id);
    chk("ovf", rsp_ovf, o);
    tick();
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    req_valid = '0;
    req_n = '0;
    rsp_ready = 1'b1;
    do_reset();
    req(0, 0);  serve(0, 32'd0, 1'b0, 2, 1'b1);
    chk("idle_busy", busy, 0);
    req(0, 10); serve(0, 32'd55, 1'b0, 12, 1'b1);
    req(2, 45); serve(2, 32'd1134903170, 1'b0, 47, 1'b1);
    req(2, 47); serve(2, 32'd2971215073, 1'b0, 49, 1'b1);
    req(1, 50); serve(1, 32'hFFFFFFFF, 1'b1, 2, 1'b1);
    req(3, 48); serve(3, 32'hFFFFFFFF, 1'b1, 2, 1'b1);
    req(0, 63); serve(0, 32'hFFFFFFFF, 1'b1, 2, 1'b1);
    req(1, 1);  serve(1, 32'd1, 1'b0, 3, 1'b1);
    chk("held_ovf_clr", rsp_ovf, 0);

    do_reset();
    req(0, 1); req(1, 2); req(2, 3); req(3, 21);
    serve(0, 32'd1, 1'b0, 3, 1'b1);
    serve(1, 32'd1, 1'b0, 4, 1'b1);
    serve(2, 32'd2, 1'b0, 5, 1'b1);
    serve(3, 32'd10946, 1'b0, 23, 1'b1);
    req(0, 2); req(3, 4);
    serve(0, 32'd1, 1'b0, 4, 1'b0);
    serve(3, 32'd3, 1'b0, 6, 1'b0);
    serve(0, 32'd1, 1'b0, 4, 1'b0);
    serve(3, 32'd3, 1'b0, 6, 1'b0);
    req_valid = '0;

    // Backpressure: response must hold while rsp_ready is low and pending requester waits.
    rsp_ready = 1'b0;
    req(1, 5);
    #1;
    chk("bp_gnt", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    req(2, 3);
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("bp_lat", cyc, 7);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 5);
      chk("bp_id", rsp_id, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_data", rsp_data, 5);
    chk("bp_idle_id", rsp_id, 1);
    serve(2, 32'd2, 1'b0, 5, 1'b1);

    // Mid-operation reset: request discarded, pointer back to requester 0.
    req(2, 40);
    #1;
    chk("mr_gnt", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    cyc = 0;
    while (cnt != 6'd20 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("mr_cnt", cnt, 20);
    rst = 1'b1;
    tick();
    chk("mr_busy", busy, 0);
    chk("mr_cnt0", cnt, 0);
    chk("mr_valid", rsp_valid, 0);
    chk("mr_data", rsp_data, 0);
    chk("mr_id", rsp_id, 0);
    chk("mr_ovf", rsp_ovf, 0);
    rst = 1'b0;
    req(1, 1); req(3, 2);
    serve(1, 32'd1, 1'b0, 3, 1'b1);
    serve(3, 32'd1, 1'b0, 4, 1'b1);
    chk("mr_no_rsp", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
